gate_exerciser: RTL and testbench

- Self-checking stimulus/response stage for the lab's 2-input logic gate cells (NOT, AND, OR, XOR, NAND).
- Sits directly upstream and downstream of the gate cells: drives the shared inputs i0/i1 through all four input combinations, samples the five gate outputs after a programmable settle time, and compares each against the expected truth table.
- Reports a per-gate sticky fail mask, a total mismatch count, and pass/done status through a start/busy/done handshake.

---
 rtl/gate_exerciser_if.sv | 28 ++
 rtl/gate_exerciser.sv | 126 ++++++++++++
 tb/tb_gate_exerciser.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gate_exerciser_if.sv
// rtl/gate_exerciser_if.sv - handshake and gate-cell signal bundle for the gate exerciser
interface gate_exerciser_if;
    logic       start;
    logic       i0;
    logic       i1;
    logic       o_not;
    logic       o_and;
    logic       o_or;
    logic       o_xor;
    logic       o_nand;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [4:0] fail_mask;

    // Controller / gate-cell side: requests runs, returns gate outputs
    modport master (
        output start, o_not, o_and, o_or, o_xor, o_nand,
        input  i0, i1, busy, done, pass, err_count, fail_mask
    );

    // Exerciser side
    modport slave (
        input  start, o_not, o_and, o_or, o_xor, o_nand,
        output i0, i1, busy, done, pass, err_count, fail_mask
    );
endinterface

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - drives all four input vectors into the gate cells and checks their outputs
module gate_exerciser #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    gate_exerciser_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       i0_q, i0_d;
    logic       i1_q, i1_d;
    logic [4:0] err_q, err_d;
    logic [4:0] mask_q, mask_d;
    logic [1:0] nxt_idx;
    logic [4:0] exp_vec;
    logic [4:0] obs_vec;
    logic [4:0] miss;
    logic [2:0] miss_cnt;
    logic       busy_c;
    logic       done_c;

    // Expected outputs come from the registered i0/i1, which is exactly what the cells see
    assign exp_vec  = {~(i0_q & i1_q), i0_q ^ i1_q, i0_q | i1_q, i0_q & i1_q, ~i0_q};
    assign obs_vec  = {bus.o_nand, bus.o_xor, bus.o_or, bus.o_and, bus.o_not};
    assign miss     = obs_vec ^ exp_vec;
    assign miss_cnt = {2'b00, miss[0]} + {2'b00, miss[1]} + {2'b00, miss[2]}
                    + {2'b00, miss[3]} + {2'b00, miss[4]};

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            i0_q    <= 1'b0;
            i1_q    <= 1'b0;
            err_q   <= 5'd0;
            mask_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            i0_q    <= i0_d;
            i1_q    <= i1_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state and datapath update; start is only honoured outside a run
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        i0_d    = i0_q;
        i1_d    = i1_q;
        err_d   = err_q;
        mask_d  = mask_q;
        nxt_idx = idx_q + 2'd1;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    err_d   = 5'd0;
                    mask_d  = 5'd0;
                    idx_d   = 2'd0;
                    i0_d    = 1'b0;
                    i1_d    = 1'b0;
                    cnt_d   = SETTLE_LD;
                    state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                err_d  = err_q + {2'b00, miss_cnt};
                mask_d = mask_q | miss;
                if (idx_q != 2'd3) begin
                    idx_d   = nxt_idx;
                    i0_d    = nxt_idx[0];
                    i1_d    = nxt_idx[1];
                    cnt_d   = SETTLE_LD;
                    state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end else begin
                    idx_d   = 2'd0;
                    i0_d    = 1'b0;
                    i1_d    = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            SETTLE, CHECK: busy_c = 1'b1;
            DONE:          done_c = 1'b1;
            default:       ;
        endcase
    end

    assign bus.i0        = i0_q;
    assign bus.i1        = i1_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.pass      = done_c && (err_q == 5'd0);
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - scoreboard bench for gate_exerciser with modelled good and faulty gate cells
module tb_gate_exerciser;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   sel   = 0;
    int   mode  = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gate_exerciser_if if0 ();
    gate_exerciser_if if1 ();
    gate_exerciser_if if3 ();

    gate_exerciser #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gate_exerciser #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    gate_exerciser #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // Gate-cell model: mode 0 good, 1 xor stuck at 0, 2 non-inverting not, 3 one-register delay
    function automatic logic [4:0] gate_out(input int m, input logic a, input logic b);
        logic [4:0] g;
        g = {~(a & b), a ^ b, a | b, a & b, ~a};
        if (m == 1) g[3] = 1'b0;
        if (m == 2) g[0] = a;
        return g;
    endfunction

    logic [4:0] dly0, dly1, dly3, g0, g1, g3;

    always @(posedge clk) begin
        dly0 <= gate_out(0, if0.i0, if0.i1);
        dly1 <= gate_out(0, if1.i0, if1.i1);
        dly3 <= gate_out(0, if3.i0, if3.i1);
    end

    assign g0 = (mode == 3) ? dly0 : gate_out(mode, if0.i0, if0.i1);
    assign g1 = (mode == 3) ? dly1 : gate_out(mode, if1.i0, if1.i1);
    assign g3 = (mode == 3) ? dly3 : gate_out(mode, if3.i0, if3.i1);

    assign {if0.o_nand, if0.o_xor, if0.o_or, if0.o_and, if0.o_not} = g0;
    assign {if1.o_nand, if1.o_xor, if1.o_or, if1.o_and, if1.o_not} = g1;
    assign {if3.o_nand, if3.o_xor, if3.o_or, if3.o_and, if3.o_not} = g3;

    assign if0.start = start && (sel == 0);
    assign if1.start = start && (sel == 1);
    assign if3.start = start && (sel == 2);

    // Observed outputs of the selected instance: {i1,i0,busy,done,pass,err[4:0],mask[4:0]}
    logic [14:0] obs;
    always_comb begin
        case (sel)
            0:       obs = {if0.i1, if0.i0, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask};
            1:       obs = {if1.i1, if1.i0, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_mask};
            default: obs = {if3.i1, if3.i0, if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_mask};
        endcase
    end

    typedef struct {
        int err;
        int mask;
        int edges;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full run: push expected result, pulse start, track vectors, compare on done
    task automatic run(input int s_sel, input int settle, input int m,
                       input int e_err, input int e_mask, input bit restart);
        int   edges;
        bit   got;
        exp_t e;
        sel  = s_sel;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{e_err, e_mask, 4 * (settle + 1)});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", int'(obs[12]), 1);
        check_val("err_cleared", int'(obs[9:5]), 0);
        check_val("mask_cleared", int'(obs[4:0]), 0);
        check_val("vec0", int'(obs[14:13]), 0);
        edges = 0;
        got   = 1'b0;
        while (edges < 100 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = restart && (edges == 3);
            if ((edges % (settle + 1)) == 0 && edges < 4 * (settle + 1))
                check_val($sformatf("vec_at_edge%0d", edges), int'(obs[14:13]), edges / (settle + 1));
            if (obs[11]) got = 1'b1;
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            check_val("done_timeout", 0, 1);
        end else begin
            check_val("done_edges", edges, e.edges);
            check_val("err_count", int'(obs[9:5]), e.err);
            check_val("fail_mask", int'(obs[4:0]), e.mask);
            check_val("pass", int'(obs[10]), (e.err == 0) ? 1 : 0);
            check_val("busy_in_done", int'(obs[12]), 0);
            check_val("vec_idle", int'(obs[14:13]), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #0;
            check_val($sformatf("reset_outputs%0d", k), int'(obs), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(1, 1, 0, 0, 0, 1'b0);
        run(1, 1, 1, 2, 5'b01000, 1'b0);
        run(1, 1, 2, 4, 5'b00001, 1'b0);
        run(0, 0, 3, 8, 5'b11111, 1'b0);
        run(1, 1, 3, 0, 0, 1'b0);
        run(1, 1, 0, 0, 0, 1'b1);

        // Asynchronous reset in the middle of a run
        sel  = 1;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("vec1_before_reset", int'(obs[14:13]), 1);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", int'(obs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(2, 3, 1, 2, 5'b01000, 1'b0);
        run(2, 3, 0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
